// File: rtl/ibex_register_file_fpga_mp_pkg.sv
// Shared types and constants for the multi-port FPGA register file.
// Holds the clear-sequencer state type and the address validity rule.
package ibex_register_file_fpga_mp_pkg;

    typedef enum logic {
        RfClear = 1'b0,
        RfReady = 1'b1
    } rf_init_state_e;

    localparam int unsigned RF_MAX_READ_PORTS = 4;

    // x0 is hardwired to zero; under RV32E the upper 16 indices do not exist.
    function automatic logic rf_addr_valid(input logic [4:0] addr, input bit rv32e);
        return (addr != 5'd0) && !(rv32e && addr[4]);
    endfunction

endpackage

// File: rtl/ibex_register_file_fpga_mp_bank.sv
// Resetless 1W1R LUTRAM bank with asynchronous read; x0/RV32E gating lives in the parent.
// Latency: write on rising edge, read combinational. No backpressure.
module ibex_register_file_fpga_bank #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic [AddrWidth-1:0] i_raddr,
    output logic [DataWidth-1:0] o_rdata
);

    // No reset on the array so synthesis can map it onto distributed RAM.
    logic [DataWidth-1:0] r_mem [2**AddrWidth];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ibex_register_file_fpga_mp.sv
// Multi-read-port FPGA register file with a clear-on-reset/on-request sequencer.
// Latency: read 0 or 1 cycle (ReadLatency); writes dropped with wr_err_o while clearing.
module ibex_register_file_fpga_mp
    import ibex_register_file_fpga_mp_pkg::*;
#(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumReadPorts = 2,
    parameter int unsigned ReadLatency  = 0,
    parameter bit          WriteBypass  = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [4:0]                        waddr_i,
    input  logic [DataWidth-1:0]              wdata_i,
    input  logic                              we_i,
    input  logic                              clear_req_i,
    output logic                              init_done_o,
    output logic                              wr_err_o
);

    localparam int unsigned AW = RV32E ? 4 : 5;
    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = '1;

    if (NumReadPorts < 1 || NumReadPorts > RF_MAX_READ_PORTS) begin : g_bad_ports
        $fatal(1, "NumReadPorts must be in 1..4");
    end
    if (ReadLatency > 1) begin : g_bad_latency
        $fatal(1, "ReadLatency must be 0 or 1");
    end

    rf_init_state_e r_state, w_state_nxt;
    logic [AW-1:0]  r_cnt, w_cnt_nxt;
    logic           r_init_done;
    logic           r_wr_err;

    logic                 w_clearing;
    logic                 w_wvalid;
    logic                 w_bank_we;
    logic [AW-1:0]        w_bank_waddr;
    logic [DataWidth-1:0] w_bank_wdata;

    assign w_clearing = (r_state == RfClear);
    assign w_wvalid   = rf_addr_valid(waddr_i, RV32E);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RfClear: begin
                w_cnt_nxt = r_cnt + CNT_FIRST;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = RfReady;
                    w_cnt_nxt   = CNT_FIRST;
                end
            end
            RfReady: begin
                if (clear_req_i) begin
                    w_state_nxt = RfClear;
                    w_cnt_nxt   = CNT_FIRST;
                end
            end
            default: begin
                w_state_nxt = RfClear;
                w_cnt_nxt   = CNT_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RfClear;
            r_cnt       <= CNT_FIRST;
            r_init_done <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= (w_state_nxt == RfReady);
            r_wr_err    <= w_clearing & we_i & (waddr_i != 5'd0);
        end
    end

    assign init_done_o = r_init_done;
    assign wr_err_o    = r_wr_err;

    // The sequencer owns the write port while clearing; external writes are dropped.
    assign w_bank_we    = w_clearing | (we_i & w_wvalid);
    assign w_bank_waddr = w_clearing ? r_cnt : waddr_i[AW-1:0];
    assign w_bank_wdata = w_clearing ? '0 : wdata_i;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
        logic [4:0]           w_raddr;
        logic                 w_rvalid;
        logic                 w_bypass;
        logic [DataWidth-1:0] w_bank_rdata;
        logic [DataWidth-1:0] w_rd;

        assign w_raddr  = raddr_i[p*5 +: 5];
        assign w_rvalid = rf_addr_valid(w_raddr, RV32E);
        assign w_bypass = WriteBypass && we_i && !w_clearing && (waddr_i == w_raddr) && w_rvalid;

        ibex_register_file_fpga_bank #(
            .AddrWidth (AW),
            .DataWidth (DataWidth)
        ) u_bank (
            .i_clk   (clk_i),
            .i_we    (w_bank_we),
            .i_waddr (w_bank_waddr),
            .i_wdata (w_bank_wdata),
            .i_raddr (w_raddr[AW-1:0]),
            .o_rdata (w_bank_rdata)
        );

        always_comb begin
            w_rd = w_bank_rdata;
            if (w_clearing || !w_rvalid) begin
                w_rd = '0;
            end else if (w_bypass) begin
                w_rd = wdata_i;
            end
        end

        if (ReadLatency == 1) begin : g_reg
            logic [DataWidth-1:0] r_rdata;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_rd;
                end
            end
            assign rdata_o[p*DataWidth +: DataWidth] = r_rdata;
        end else begin : g_comb
            assign rdata_o[p*DataWidth +: DataWidth] = w_rd;
        end
    end

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// Bench for ibex_register_file_fpga_mp: four configurations share one stimulus stream
// and are checked each cycle against an array-level model plus literal expectations.
module tb_ibex_register_file_fpga_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  raddr [4];
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        clr;

    logic [19:0]  ra4;
    logic [127:0] rd_a;
    logic [63:0]  rd_b;
    logic [31:0]  rd_c;
    logic [31:0]  rd_d;
    logic [3:0]   done;
    logic [3:0]   err;

    assign ra4 = {raddr[3], raddr[2], raddr[1], raddr[0]};

    // A: RV32I, 4 ports, registered read. B: 2 ports, comb, bypass.
    // C: 1 port, comb, no bypass. D: RV32E, 1 port, comb, bypass.
    ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(4), .ReadLatency(1), .WriteBypass(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(ra4), .rdata_o(rd_a), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .clear_req_i(clr), .init_done_o(done[0]), .wr_err_o(err[0]));
    ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .ReadLatency(0), .WriteBypass(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(ra4[9:0]), .rdata_o(rd_b), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .clear_req_i(clr), .init_done_o(done[1]), .wr_err_o(err[1]));
    ibex_register_file_fpga_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(1), .ReadLatency(0), .WriteBypass(1'b0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(ra4[4:0]), .rdata_o(rd_c), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .clear_req_i(clr), .init_done_o(done[2]), .wr_err_o(err[2]));
    ibex_register_file_fpga_mp #(.RV32E(1'b1), .DataWidth(32), .NumReadPorts(1), .ReadLatency(0), .WriteBypass(1'b1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(ra4[4:0]), .rdata_o(rd_d), .waddr_i(waddr), .wdata_i(wdata),
        .we_i(we), .clear_req_i(clr), .init_done_o(done[3]), .wr_err_o(err[3]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model configuration per instance.
    bit e32 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int rl  [4] = '{1, 0, 0, 0};
    bit wbp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int np  [4] = '{4, 2, 1, 1};

    // Model state: register contents, ready flag, remaining clear edges.
    logic [31:0] mem [4][32];
    bit          ready [4];
    int          clr_left [4];
    logic [31:0] rl1 [4][4];
    bit          werr [4];

    function automatic bit mvalid(input int k, input logic [4:0] a);
        return (a != 5'd0) && !(e32[k] && a[4]);
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [4:0] a);
        if (!ready[k] || !mvalid(k, a)) return 32'h0;
        if (wbp[k] && we && waddr == a) return wdata;
        return mem[k][a];
    endfunction

    function automatic int nwords(input int k);
        return e32[k] ? 16 : 32;
    endfunction

    task automatic mzero(input int k);
        for (int w = 0; w < 32; w++) mem[k][w] = 32'h0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                ready[k]    = 1'b0;
                clr_left[k] = nwords(k) - 1;
                werr[k]     = 1'b0;
                mzero(k);
                for (int p = 0; p < 4; p++) rl1[k][p] = 32'h0;
            end else begin
                for (int p = 0; p < 4; p++) rl1[k][p] = mread(k, raddr[p]);
                if (!ready[k]) begin
                    werr[k] = we && (waddr != 5'd0);
                    clr_left[k]--;
                    if (clr_left[k] == 0) ready[k] = 1'b1;
                end else begin
                    werr[k] = 1'b0;
                    if (we && mvalid(k, waddr)) mem[k][waddr] = wdata;
                    if (clr) begin
                        ready[k]    = 1'b0;
                        clr_left[k] = nwords(k) - 1;
                        mzero(k);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] act_rd(input int k, input int p);
        case (k)
            0:       return rd_a[p*32 +: 32];
            1:       return rd_b[p*32 +: 32];
            2:       return rd_c;
            default: return rd_d;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < np[k]; p++) begin
                chk($sformatf("rdata k%0d p%0d addr%0d", k, p, raddr[p]), act_rd(k, p),
                    (rl[k] == 1) ? rl1[k][p] : mread(k, raddr[p]));
            end
            chk($sformatf("init_done k%0d", k), {31'b0, done[k]}, {31'b0, ready[k]});
            chk($sformatf("wr_err k%0d", k), {31'b0, err[k]}, {31'b0, werr[k]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_raddr(input logic [4:0] a);
        for (int p = 0; p < 4; p++) raddr[p] = a;
    endtask

    initial begin
        int n;
        int fa;
        int fd;
        rst_n = 1'b0;
        we    = 1'b0;
        clr   = 1'b0;
        waddr = 5'd0;
        wdata = 32'h0;
        set_raddr(5'd0);
        repeat (3) cyc();
        rst_n = 1'b1;

        n = 0; fa = -1; fd = -1;
        while (n < 40 && (fa < 0 || fd < 0)) begin
            @(posedge clk);
            n++;
            #1;
            if (done[0] && fa < 0) fa = n;
            if (done[3] && fd < 0) fd = n;
        end
        chk("clear length rv32i", fa, 31);
        chk("clear length rv32e", fd, 15);
        cyc();

        for (int a = 0; a < 32; a++) begin
            set_raddr(5'(a));
            cyc();
        end
        set_raddr(5'd31);
        #1 chk("x31 after reset", rd_b[31:0], 32'h0);
        cyc();

        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cyc();
        we = 1'b0;
        set_raddr(5'd5);
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("x5 A port%0d", p), rd_a[p*32 +: 32], 32'hDEADBEEF);
        #1;

        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        set_raddr(5'd0);
        #1 chk("x0 write bypass", rd_b[31:0], 32'h0);
        cyc();
        we = 1'b0;
        #1 chk("x0 read A", rd_a[31:0], 32'h0);
        cyc();

        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        set_raddr(5'd7);
        #1;
        chk("bypass x7", rd_b[31:0], 32'hA5A5A5A5);
        chk("no bypass x7", rd_c, 32'h0);
        cyc();
        we = 1'b0;

        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i);
            cyc();
        end
        we = 1'b0;
        set_raddr(5'd17);
        #1;
        chk("rv32e x17", rd_d, 32'h0);
        chk("rv32i x17", rd_b[31:0], 32'd17);
        cyc();

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
        cyc();
        we = 1'b0;
        #1 chk("wr_err during clear", {31'b0, err[0]}, 32'd1);
        n = 1;
        while (n < 40 && !done[0]) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("re-clear length", n, 31);
        #1;
        set_raddr(5'd3);
        #1 chk("x3 after clear", rd_b[31:0], 32'h0);
        cyc();
        for (int a = 0; a < 32; a++) begin
            set_raddr(5'(a));
            cyc();
        end

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (10) cyc();
        rst_n = 1'b0;
        #1 chk("done low in reset", {31'b0, done[0]}, 32'd0);
        cyc();
        rst_n = 1'b1;
        n = 0;
        while (n < 40 && !done[0]) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("clear after mid-clear reset", n, 31);
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
